// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small synchronous byte FIFO feeding a fixed-divider UART transmitter
// (start bit, DBIT data bits LSB first, one stop bit).
module uart_tx_fifo #(
  parameter int DBIT    = 8,
  parameter int CLK_DIV = 5208,
  parameter int ADDR_W  = 3
) (
  input  logic            clk,
  input  logic            r,
  input  logic            we,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            full,
  output logic            empty,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            overflow,
  output logic [1:0]      dbg_state
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DBIT-1:0]     shift_q, shift_d, shifted;
  logic                tx_q, tx_d;

  logic [DBIT-1:0]     mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]     count_q, count_d;
  logic                full_q, empty_q, overflow_q;

  logic                pop, push, last_baud;

  // Handshake: we is a strobe with no ready. A byte is taken when we && (!full || pop);
  // a pop frees a slot on the same edge, so a write into a full FIFO is kept then.
  assign pop       = (state_q == S_IDLE) && !empty_q;
  assign push      = we && (!full_q || pop);
  assign last_baud = (baud_q == BAUD_W'(CLK_DIV - 1));
  assign shifted   = shift_q >> 1;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = S_START;
          baud_d  = '0;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (last_baud) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (last_baud) begin
          baud_d  = '0;
          shift_d = shifted;
          if (bit_q == BIT_W'(DBIT - 1)) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            tx_d  = shifted[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (last_baud) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r && push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      count_q    <= count_d;
      full_q     <= (count_d == (ADDR_W+1)'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= we && full_q && !pop;
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
    end
  end

  assign tx           = tx_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign overflow     = overflow_q;
  assign tx_busy      = (state_q != S_IDLE);
  assign tx_done_tick = (state_q == S_STOP) && last_baud;
  assign dbg_state    = state_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Downstream consumer of the BCD-to-ASCII sequencer (the block that emits we/datatx).
- Buffers bytes written by that sequencer in a small synchronous FIFO.
- Serialises each byte onto a UART line: 8N1 by default, LSB first, fixed clock divider.
- Sits between the sequencer and the board TX pin; the sequencer writes one byte per clock with no back-pressure, so the FIFO absorbs complete bursts.

Parameters:
- DBIT, 8, data bits per frame.
- CLK_DIV, 5208, clocks per bit period (50 MHz / 9600 baud); legal range ≥ 2.
- ADDR_W, 3, FIFO address width; depth = 2^ADDR_W = 8 entries.

Ports:
- clk  in  1  system clock, rising edge.
- r  in  1  reset, synchronous, active-high.
- we  in  1  write strobe; one byte accepted per clock while high and not full.
- din  in  DBIT  byte to transmit (driven by the sequencer's datatx).
- tx  out  1  serial line, idle high, registered.
- full  out  1  FIFO holds 2^ADDR_W bytes.
- empty  out  1  FIFO holds 0 bytes.
- tx_busy  out  1  high in START/DATA/STOP.
- tx_done_tick  out  1  one-clock pulse at the end of each stop bit.
- overflow  out  1  one-clock pulse when a write is dropped.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (r sampled high at an edge), effective after that edge:
  - tx=1, empty=1, full=0, tx_busy=0, tx_done_tick=0, overflow=0.
  - FIFO pointers and count cleared; state IDLE; baud counter and bit counter 0.
  - Reset mid-frame aborts the frame immediately; no done tick is issued.
- FIFO:
  - Circular buffer with wrapping pointers and a count of width ADDR_W+1.
  - Write: when we && !full at an edge, din is stored and the count increments.
  - we && full: byte dropped, overflow=1 for the following cycle, contents unchanged.
  - Pop happens only on the IDLE→START transition. Write and pop on the same edge are both performed and the count is unchanged. This includes the full case, where the write is accepted because full is evaluated before that edge.
  - full and empty are registered and reflect the count after each edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !empty at an edge: pop the head into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLK_DIV clocks, then go to DATA with bit counter 0.
  - DATA: tx=shift[0] for CLK_DIV clocks. Then shift right and increment the bit counter; after DBIT bits go to STOP.
  - STOP: tx=1 for CLK_DIV clocks. On the final clock assert tx_done_tick for one cycle and go to IDLE.
- Baud counter counts 0..CLK_DIV-1 within each bit and wraps to 0 on each bit transition.
- Latency and timing:
  - A byte written at edge k into an empty FIFO makes empty=0 after edge k.
  - It is popped at edge k+1; tx falls after edge k+1.
  - Frame length is (DBIT+2)*CLK_DIV clocks.
  - Back-to-back frames are separated by exactly one IDLE clock with tx=1.
- tx is driven from a register; no combinational path from we/din to tx.

Test Plan:
1. Hold r=1 for 3 clocks, then release -> tx=1, empty=1, full=0, tx_busy=0, tx_done_tick=0, overflow=0 throughout.
2. CLK_DIV=4: write 0x31 once -> tx=0 for 4 clocks starting 1 clock after the write edge. Bits 1,0,0,0,1,1,0,0 follow, 4 clocks each, then stop high for 4 clocks. Exactly one tx_done_tick at clock 40 of the frame; empty=1 after the pop.
3. Burst "1.23.4" (0x31,0x2E,0x32,0x33,0x2E,0x34) on 6 consecutive clocks, as the sequencer emits it -> six frames decode in order. Frames are separated by 1 idle clock; 6 done ticks; overflow never asserts; full never asserts.
4. Write 10 bytes 0x00..0x09 on consecutive clocks from empty -> full=1 after the 9th write edge. The 10th write (0x09) is dropped with a single overflow pulse; 0x00..0x08 are transmitted in order; empty=1 after the last pop.
5. Fill the FIFO full, then drive we with 0xA5 on the exact edge the FSM pops -> the write is accepted and full stays 1. 0xA5 is transmitted last; no overflow.
6. Assert r for one clock during DATA bit 3 -> tx=1 on the next cycle, empty=1, tx_busy=0, no done tick. Then write 0x55 -> a normal, correctly timed frame.
